// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with stall, flush (bubble) and halt capture.
// Optional bubble counter output enabled by defining EX_MEM_BUBBLE_CNT_EN.
module ex_mem_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [15:0] EX_ALUOut,
  input  logic [15:0] EX_StoreData,
  input  logic [3:0]  EX_RegRd,
  input  logic [3:0]  EX_RegRt,
  input  logic        EX_RegWrite,
  input  logic        EX_MemWrite,
  input  logic        EX_MemRead,
  input  logic        EX_MemToReg,
  input  logic        EX_Halt,
  output logic [15:0] MEM_ALUOut,
  output logic [15:0] MEM_StoreData,
  output logic [3:0]  MEM_RegRd,
  output logic [3:0]  MEM_RegRt,
  output logic        MEM_RegWrite,
  output logic        MEM_MemWrite,
  output logic        MEM_MemRead,
  output logic        MEM_MemToReg,
  output logic        MEM_Halt,
  output logic        MEM_Valid,
  output logic        halted
`ifdef EX_MEM_BUBBLE_CNT_EN
  ,
  output logic [15:0] bubble_cnt
`endif
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t state_q;
  state_t state_d;
  logic   load_en;
  logic   bubble_en;

  // Decide this cycle's action: flush beats stall, and a halt is only taken on a real load.
  always_comb begin
    state_d   = state_q;
    load_en   = 1'b0;
    bubble_en = 1'b0;
    if (state_q == RUN) begin
      if (flush) begin
        bubble_en = 1'b1;
      end else if (!stall) begin
        load_en = 1'b1;
        if (EX_Halt) begin
          state_d = HALTED;
        end
      end
    end
  end

  // State register; reset always returns to RUN, even out of HALTED.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Stage contents: cleared on reset or bubble, captured on load, held otherwise.
  always_ff @(posedge clk) begin
    if (rst || bubble_en) begin
      MEM_ALUOut    <= 16'h0000;
      MEM_StoreData <= 16'h0000;
      MEM_RegRd     <= 4'h0;
      MEM_RegRt     <= 4'h0;
      MEM_RegWrite  <= 1'b0;
      MEM_MemWrite  <= 1'b0;
      MEM_MemRead   <= 1'b0;
      MEM_MemToReg  <= 1'b0;
      MEM_Halt      <= 1'b0;
      MEM_Valid     <= 1'b0;
    end else if (load_en) begin
      MEM_ALUOut    <= EX_ALUOut;
      MEM_StoreData <= EX_StoreData;
      MEM_RegRd     <= EX_RegRd;
      MEM_RegRt     <= EX_RegRt;
      MEM_RegWrite  <= EX_RegWrite && (EX_RegRd != 4'h0);
      MEM_MemWrite  <= EX_MemWrite;
      MEM_MemRead   <= EX_MemRead;
      MEM_MemToReg  <= EX_MemToReg;
      MEM_Halt      <= EX_Halt;
      MEM_Valid     <= 1'b1;
    end
  end

  assign halted = (state_q == HALTED);

`ifdef EX_MEM_BUBBLE_CNT_EN
  // Count flushed cycles while running, saturating rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt <= 16'h0000;
    end else if (bubble_en && (bubble_cnt != 16'hFFFF)) begin
      bubble_cnt <= bubble_cnt + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// Testbench for ex_mem_reg: directed scenarios followed by randomized traffic
// compared against a behavioural model of the stage register.
module tb_ex_mem_reg;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic [15:0] EX_ALUOut, EX_StoreData;
  logic [3:0]  EX_RegRd, EX_RegRt;
  logic        EX_RegWrite, EX_MemWrite, EX_MemRead, EX_MemToReg, EX_Halt;
  logic [15:0] MEM_ALUOut, MEM_StoreData;
  logic [3:0]  MEM_RegRd, MEM_RegRt;
  logic        MEM_RegWrite, MEM_MemWrite, MEM_MemRead, MEM_MemToReg, MEM_Halt, MEM_Valid;
  logic        halted;
`ifdef EX_MEM_BUBBLE_CNT_EN
  logic [15:0] bubble_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: a snapshot of what the MEM stage should hold.
  typedef struct {
    logic [15:0] alu, sd;
    logic [3:0]  rd, rt;
    logic        rw, mw, mr, mtr, hlt, vld;
  } stage_t;

  stage_t      m_stage;
  logic        m_halted;
  int          m_bubbles;

  ex_mem_reg dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .EX_ALUOut(EX_ALUOut), .EX_StoreData(EX_StoreData),
    .EX_RegRd(EX_RegRd), .EX_RegRt(EX_RegRt),
    .EX_RegWrite(EX_RegWrite), .EX_MemWrite(EX_MemWrite), .EX_MemRead(EX_MemRead),
    .EX_MemToReg(EX_MemToReg), .EX_Halt(EX_Halt),
    .MEM_ALUOut(MEM_ALUOut), .MEM_StoreData(MEM_StoreData),
    .MEM_RegRd(MEM_RegRd), .MEM_RegRt(MEM_RegRt),
    .MEM_RegWrite(MEM_RegWrite), .MEM_MemWrite(MEM_MemWrite), .MEM_MemRead(MEM_MemRead),
    .MEM_MemToReg(MEM_MemToReg), .MEM_Halt(MEM_Halt), .MEM_Valid(MEM_Valid),
    .halted(halted)
`ifdef EX_MEM_BUBBLE_CNT_EN
    , .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Advance the model by one clock using the inputs present at the edge.
  task automatic modelStep();
    stage_t empty;
    empty = '{alu: 16'h0, sd: 16'h0, rd: 4'h0, rt: 4'h0, rw: 1'b0, mw: 1'b0,
              mr: 1'b0, mtr: 1'b0, hlt: 1'b0, vld: 1'b0};
    if (rst) begin
      m_stage   = empty;
      m_halted  = 1'b0;
      m_bubbles = 0;
    end else if (!m_halted) begin
      if (flush) begin
        m_stage = empty;
        if (m_bubbles < 65535) m_bubbles++;
      end else if (!stall) begin
        m_stage.alu = EX_ALUOut;
        m_stage.sd  = EX_StoreData;
        m_stage.rd  = EX_RegRd;
        m_stage.rt  = EX_RegRt;
        m_stage.rw  = (EX_RegRd == 4'h0) ? 1'b0 : EX_RegWrite;
        m_stage.mw  = EX_MemWrite;
        m_stage.mr  = EX_MemRead;
        m_stage.mtr = EX_MemToReg;
        m_stage.hlt = EX_Halt;
        m_stage.vld = 1'b1;
        if (EX_Halt) m_halted = 1'b1;
      end
    end
  endtask

  // Drive one cycle of inputs, clock it, and advance the model.
  task automatic applyStimulus(input logic r, input logic s, input logic f,
                               input logic [15:0] alu, input logic [15:0] sd,
                               input logic [3:0] rd, input logic [3:0] rt,
                               input logic rw, input logic mw, input logic mr,
                               input logic mtr, input logic hlt);
    rst = r; stall = s; flush = f;
    EX_ALUOut = alu; EX_StoreData = sd; EX_RegRd = rd; EX_RegRt = rt;
    EX_RegWrite = rw; EX_MemWrite = mw; EX_MemRead = mr; EX_MemToReg = mtr; EX_Halt = hlt;
    @(posedge clk);
    modelStep();
    @(negedge clk);
  endtask

  task automatic checkField(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model.
  task automatic checkOutput(input string step);
    checkField({step, ":ALUOut"},    MEM_ALUOut,    m_stage.alu);
    checkField({step, ":StoreData"}, MEM_StoreData, m_stage.sd);
    checkField({step, ":RegRd"},     {12'h0, MEM_RegRd}, {12'h0, m_stage.rd});
    checkField({step, ":RegRt"},     {12'h0, MEM_RegRt}, {12'h0, m_stage.rt});
    checkField({step, ":ctrl"},
               {10'h0, MEM_RegWrite, MEM_MemWrite, MEM_MemRead, MEM_MemToReg, MEM_Halt, MEM_Valid},
               {10'h0, m_stage.rw, m_stage.mw, m_stage.mr, m_stage.mtr, m_stage.hlt, m_stage.vld});
    checkField({step, ":halted"},    {15'h0, halted}, {15'h0, m_halted});
`ifdef EX_MEM_BUBBLE_CNT_EN
    checkField({step, ":bubble_cnt"}, bubble_cnt, m_bubbles[15:0]);
`endif
  endtask

  // Directed scenarios first, then randomized traffic, then the summary.
  initial begin
    m_stage  = '{alu: 16'hxxxx, sd: 16'hxxxx, rd: 4'hx, rt: 4'hx, rw: 1'bx, mw: 1'bx,
                 mr: 1'bx, mtr: 1'bx, hlt: 1'bx, vld: 1'bx};
    m_halted = 1'bx;
    m_bubbles = 0;
    @(negedge clk);

    applyStimulus(1, 0, 0, 16'hAAAA, 16'h5555, 4'h7, 4'h3, 1, 1, 1, 1, 1);
    checkOutput("reset");
    checkField("reset:Valid_const", {15'h0, MEM_Valid}, 16'h0);

    applyStimulus(0, 0, 0, 16'h1234, 16'h0042, 4'h5, 4'h2, 1, 0, 0, 0, 0);
    checkOutput("load");
    checkField("load:ALUOut_const", MEM_ALUOut, 16'h1234);
    checkField("load:RegRd_const",  {12'h0, MEM_RegRd}, 16'h0005);
    checkField("load:Valid_const",  {14'h0, MEM_RegWrite, MEM_Valid}, 16'h0003);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 0, 16'hBEEF, 16'hCAFE, 4'h9, 4'h9, 0, 1, 1, 0, 1);
      checkOutput("stall");
      checkField("stall:ALUOut_const", MEM_ALUOut, 16'h1234);
    end

    applyStimulus(0, 1, 1, 16'hBEEF, 16'h1111, 4'h6, 4'h6, 1, 1, 0, 0, 1);
    checkOutput("flush_stall");
    checkField("flush_stall:ctrl_const", {10'h0, MEM_RegWrite, MEM_MemWrite, MEM_MemRead,
               MEM_MemToReg, MEM_Halt, MEM_Valid}, 16'h0000);
`ifdef EX_MEM_BUBBLE_CNT_EN
    checkField("flush_stall:bubble_const", bubble_cnt, 16'h0001);
`endif

    applyStimulus(0, 0, 0, 16'h0F0F, 16'h00FF, 4'h0, 4'h1, 1, 0, 1, 1, 0);
    checkOutput("r0_qualify");
    checkField("r0_qualify:rw_valid", {14'h0, MEM_RegWrite, MEM_Valid}, 16'h0001);

    applyStimulus(0, 0, 0, 16'h7777, 16'h8888, 4'hA, 4'hB, 1, 1, 0, 0, 1);
    checkOutput("halt");
    checkField("halt:flags_const", {14'h0, MEM_Halt, halted}, 16'h0003);
    applyStimulus(0, 0, 1, 16'h1357, 16'h2468, 4'h3, 4'h4, 0, 0, 1, 1, 0);
    checkOutput("halted_flush");
    applyStimulus(0, 0, 0, 16'h9999, 16'h3333, 4'hC, 4'hD, 1, 0, 0, 0, 0);
    checkOutput("halted_load");
    checkField("halted_load:ALUOut_const", MEM_ALUOut, 16'h7777);
    applyStimulus(1, 1, 1, 16'h9999, 16'h3333, 4'hC, 4'hD, 1, 0, 0, 0, 0);
    checkOutput("halt_reset");
    checkField("halt_reset:halted_const", {15'h0, halted}, 16'h0);

    applyStimulus(0, 0, 0, 16'h2222, 16'h4444, 4'h8, 4'h2, 1, 0, 1, 0, 1);
    checkOutput("halt_not_on_stall_pre");
    applyStimulus(1, 0, 0, 16'h0, 16'h0, 4'h0, 4'h0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 16'hABCD, 16'h0101, 4'h4, 4'h5, 1, 1, 1, 1, 0);
    applyStimulus(0, 1, 0, 16'hFFFF, 16'hFFFF, 4'hF, 4'hF, 1, 1, 1, 1, 1);
    checkOutput("stall_with_halt");
    applyStimulus(0, 0, 1, 16'hFFFF, 16'hFFFF, 4'hF, 4'hF, 1, 1, 1, 1, 1);
    checkOutput("flush_with_halt");
    applyStimulus(0, 0, 0, 16'hABCD, 16'h0101, 4'h4, 4'h5, 1, 1, 1, 1, 0);
    applyStimulus(1, 1, 0, 16'hFFFF, 16'hFFFF, 4'hF, 4'hF, 1, 1, 1, 1, 0);
    checkOutput("reset_mid_stall");
    checkField("reset_mid_stall:ALUOut_const", MEM_ALUOut, 16'h0000);

    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 24) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 5) == 0, 16'($urandom), 16'($urandom),
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                    $urandom_range(0, 19) == 0);
      checkOutput("random");
    end

    $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_mem_reg.md
EX_MEM_REG -- requirements
Module: ex_mem_reg

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset, sampled on rising edge of clk.
REQ-003 SHALL have port stall, input, 1, hold all stage contents this cycle.
REQ-004 SHALL have port flush, input, 1, load a bubble instead of EX contents.
REQ-005 SHALL have ports EX_ALUOut, EX_StoreData (post-forwarding Rt value), input, 16 each, EX-stage data.
REQ-006 SHALL have ports EX_RegRd, EX_RegRt, input, 4 each, EX-stage destination and Rt register numbers.
REQ-007 SHALL have ports EX_RegWrite, EX_MemWrite, EX_MemRead, EX_MemToReg, EX_Halt, input, 1 each, EX-stage control.
REQ-008 SHALL have outputs MEM_ALUOut, MEM_StoreData (16), MEM_RegRd, MEM_RegRt (4), MEM_RegWrite, MEM_MemWrite, MEM_MemRead, MEM_MemToReg, MEM_Halt, MEM_Valid (1): registered EX-stage values; MEM_RegRd/MEM_RegRt/MEM_RegWrite/MEM_MemWrite feed the forwarding unit directly.
REQ-009 SHALL have output halted, 1, high while in state HALTED.

Function
REQ-010 SHALL implement two states: RUN, HALTED.
REQ-011 SHALL, in RUN, apply per-cycle priority rst > flush > stall > load.
REQ-012 SHALL, on load, capture every EX_* input into its MEM_* counterpart with 1-cycle latency and set MEM_Valid=1.
REQ-013 SHALL, on stall, hold every MEM_* output and MEM_Valid unchanged.
REQ-014 SHALL, on flush, load a bubble: all MEM_* control bits 0, MEM_RegRd=0, MEM_RegRt=0, MEM_ALUOut=0, MEM_StoreData=0, MEM_Valid=0.
REQ-015 SHALL treat flush and stall asserted together as flush (bubble loaded, stall ignored).
REQ-016 SHALL qualify control capture: if EX_RegRd==0, MEM_RegWrite SHALL be loaded as 0 regardless of EX_RegWrite.
REQ-017 SHALL transition RUN -> HALTED on the edge at which a load with EX_Halt=1 occurs; MEM_Halt=1 and halted=1 from the next cycle.
REQ-018 SHALL, in HALTED, ignore stall, flush and all EX_* inputs and hold all outputs; only rst exits HALTED.
REQ-019 SHALL not transition to HALTED when EX_Halt=1 coincides with stall or flush.
REQ-020 SHALL contain no combinational path from any input to any output.

Reset
REQ-021 SHALL, on rst, set all 16-bit and 4-bit outputs to 0, all 1-bit outputs to 0 (MEM_Valid=0, halted=0), state to RUN.
REQ-022 SHALL give rst priority over stall, flush and HALTED, including mid-stall.

Configuration
REQ-023 SHALL, with EX_MEM_BUBBLE_CNT_EN defined, add output bubble_cnt (16): counts cycles in RUN in which flush=1, reset to 0, saturates at 16'hFFFF, frozen in HALTED.
REQ-024 SHALL, without EX_MEM_BUBBLE_CNT_EN, omit bubble_cnt port and counter logic; all other behaviour identical.

Verification
REQ-025 Load: EX_ALUOut=16'h1234, EX_RegRd=4'h5, EX_RegWrite=1, no stall/flush -> next cycle MEM_ALUOut=16'h1234, MEM_RegRd=5, MEM_RegWrite=1, MEM_Valid=1.
REQ-026 Stall hold: load as above, then stall=1 for 3 cycles with EX_ALUOut=16'hBEEF -> MEM_ALUOut stays 16'h1234 for all 3 cycles.
REQ-027 Flush+stall: stall=1, flush=1, EX_MemWrite=1 -> next cycle all MEM_* control 0, MEM_RegRd=0, MEM_Valid=0; with EX_MEM_BUBBLE_CNT_EN bubble_cnt increments by 1.
REQ-028 R0 qualify: EX_RegRd=0, EX_RegWrite=1 -> MEM_RegWrite=0, MEM_Valid=1.
REQ-029 Halt: load with EX_Halt=1 -> next cycle MEM_Halt=1, halted=1; subsequent flush and new EX_* leave outputs unchanged; rst=1 -> next cycle all outputs 0, state RUN.
REQ-030 Reset mid-stall: stall=1, rst=1 with valid contents -> next cycle all outputs 0, MEM_Valid=0.
